video_line_capture: RTL and testbench
=====================================

VIDEO_LINE_CAPTURE -- requirements
Module: video_line_capture

Interface
REQ-001 Parameters SHALL be as follows.
  - DECIM, default 3: ADC samples averaged per output pixel.
  - OUT_WIDTH, default 640: pixels emitted per line.
  - MAX_LINES, default 263: line count limit per field.
  - BLACK_LEVEL, default 1024: ADC code of black.
  - GAIN_Q8, default 11: luma gain in Q8.
  - FIFO_DEPTH, default 4: output buffer entries, power of 2.
REQ-002 Ports SHALL be as follows.
  - clk  in  1: single clock; all logic in this domain.
  - rst_n  in  1: reset, asynchronous assert, active-low.
  - sample_valid  in  1: ADC sample strobe.
  - adc_data  in  12: raw composite sample.
  - h_sync_pulse  in  1: start-of-line strobe, qualified by sample_valid.
  - v_sync_pulse  in  1: start-of-field strobe, coincident with h_sync_pulse.
  - active_video  in  1: active pixel window.
  - pix_valid  out  1: output pixel available.
  - pix_ready  in  1: downstream accepts pixel.
  - pix_data  out  8: luma.
  - pix_x  out  10: pixel column.
  - pix_y  out  10: line number.
  - pix_sof  out  1: first pixel of field.
  - pix_eol  out  1: last pixel of line.
  - overflow  out  1: sticky pixel-drop flag.

Function
REQ-003 Inputs SHALL be sampled only on cycles with sample_valid=1; all other cycles leave state unchanged except the output handshake.
REQ-004 The FSM SHALL have states IDLE, WAIT_LINE, CAPTURE and DONE_LINE.
REQ-005 IDLE -> WAIT_LINE on v_sync_pulse; y_cnt SHALL be set to 0 on v_sync_pulse.
REQ-006 In WAIT_LINE, an h_sync_pulse without v_sync_pulse SHALL increment y_cnt, saturating at MAX_LINES-1.
REQ-007 In WAIT_LINE, x_cnt and the accumulator SHALL be cleared on every h_sync_pulse.
REQ-008 WAIT_LINE -> CAPTURE on the first sample with active_video=1.
REQ-009 In CAPTURE, each sample SHALL add to a 14-bit accumulator; every DECIM-th sample SHALL produce one pixel and clear the accumulator.
REQ-010 Pixel value SHALL be computed as follows.
  - d = acc - DECIM*BLACK_LEVEL, floored at 0.
  - pix_data = (d*GAIN_Q8)>>8, saturated to 255.
  - Intermediate width SHALL be at least 22 bits.
REQ-011 CAPTURE -> DONE_LINE when x_cnt reaches OUT_WIDTH or active_video falls.
  - A partial group SHALL be discarded.
  - pix_eol SHALL be set only on pixel x=OUT_WIDTH-1.
REQ-012 DONE_LINE -> WAIT_LINE on the next h_sync_pulse; samples arriving in DONE_LINE SHALL be ignored.
REQ-013 v_sync_pulse in any state SHALL abort the current line, discard the partial group, set y_cnt=0, clear x_cnt and enter WAIT_LINE.
REQ-014 pix_sof SHALL be 1 only for the pixel with x=0 and y=0.
REQ-015 Pixel production to pix_valid SHALL have a latency of 2 clk cycles when the FIFO is empty (compute register + FIFO).
REQ-016 Each pixel {data, x, y, sof, eol} SHALL be written into the FIFO; pix_valid SHALL equal FIFO not-empty.
REQ-017 A pop SHALL occur when pix_valid & pix_ready.
REQ-018 Output fields SHALL stay stable while pix_valid=1 and pix_ready=0.
REQ-019 Full-FIFO behaviour SHALL be as follows.
  - A pixel produced while the FIFO is full SHALL be dropped and overflow set.
  - Simultaneous pop and push when full SHALL succeed without drop.
REQ-020 overflow SHALL clear on v_sync_pulse unless a drop occurs in the same cycle, in which case it remains set.
REQ-021 x_cnt SHALL never exceed OUT_WIDTH.

Reset
REQ-022 On rst_n=0, asynchronously, the following SHALL hold.
  - State SHALL be IDLE.
  - x_cnt, y_cnt and the accumulator SHALL be 0.
  - The FIFO SHALL be emptied.
  - pix_valid, pix_sof, pix_eol and overflow SHALL be 0.
  - pix_data, pix_x and pix_y SHALL be 0.
REQ-023 A reset mid-line SHALL discard all buffered pixels; capture SHALL resume only after the next v_sync_pulse.

Structure
REQ-024 Package video_in_pkg SHALL hold the following.
  - The capture state enum.
  - The pixel struct {data[7:0], x[9:0], y[9:0], sof, eol}.
  - Default OUT_WIDTH and MAX_LINES constants.
REQ-025 The FIFO SHALL be a separate sub-module pixel_fifo, parameterised by depth and struct type, with count-based full/empty flags.

Verification
REQ-026 Verification SHALL cover the following scenarios.
  - Flat 2048 input, v+h sync, 1920 active samples, pix_ready=1 -> 640 pixels; pix_data=132; sof on the first pixel; eol on x=639.
  - Input 900 (below black) -> pix_data=0; input 4095 -> pix_data=255.
  - active_video drops after 1000 samples -> 333 pixels, no eol, last partial sample discarded.
  - pix_ready=0 for a full line -> 4 pixels held with stable fields, 636 dropped, overflow=1; next v_sync_pulse clears overflow.
  - v_sync_pulse mid-line at x=200 -> line aborted, next line y=0 and first pixel has sof.
  - rst_n low during CAPTURE with 3 pixels buffered -> pix_valid=0 immediately; h_sync_pulse without v_sync_pulse afterwards produces no pixels.

Source files
------------

// File: rtl/video_in_pkg.sv
// Shared types for the composite video line capture path.
// Capture states, pixel bundle and default raster limits.
package video_in_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LINE,
    CAPTURE,
    DONE_LINE
  } cap_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] x;
    logic [9:0] y;
    logic       sof;
    logic       eol;
  } pixel_t;

  localparam int DEF_OUT_WIDTH = 640;
  localparam int DEF_MAX_LINES = 263;

endpackage

// File: rtl/video_line_capture_if.sv
// ADC sample input and pixel valid/ready output bundle.
// master drives samples and ready; slave is the capture block.
interface video_line_capture_if;

  logic        sample_valid;
  logic [11:0] adc_data;
  logic        h_sync_pulse;
  logic        v_sync_pulse;
  logic        active_video;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        pix_sof;
  logic        pix_eol;
  logic        overflow;

  modport master (
    output sample_valid, adc_data,
    output h_sync_pulse, v_sync_pulse,
    output active_video, pix_ready,
    input  pix_valid, pix_data,
    input  pix_x, pix_y,
    input  pix_sof, pix_eol,
    input  overflow
  );

  modport slave (
    input  sample_valid, adc_data,
    input  h_sync_pulse, v_sync_pulse,
    input  active_video, pix_ready,
    output pix_valid, pix_data,
    output pix_x, pix_y,
    output pix_sof, pix_eol,
    output overflow
  );

endinterface

// File: rtl/pixel_fifo.sv
// Count-based pixel FIFO; DEPTH must be a power of 2.
// A push while full succeeds only when a pop happens in the same cycle.
module pixel_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_rd    = i_pop & ~o_empty;
  assign w_wr    = i_push & (~o_full | w_rd);
  assign o_data  = r_mem[r_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end

  // Storage needs no reset: outputs are qualified by the count.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/video_line_capture.sv
// Composite luma capture: decimate ADC samples, black-level and gain
// correct, tag with raster position and buffer for a valid/ready sink.
module video_line_capture
  import video_in_pkg::*;
#(
  parameter int DECIM       = 3,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int MAX_LINES   = DEF_MAX_LINES,
  parameter int BLACK_LEVEL = 1024,
  parameter int GAIN_Q8     = 11,
  parameter int FIFO_DEPTH  = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  video_line_capture_if.slave bus
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);
  localparam logic [13:0]   BLK     = 14'(DECIM * BLACK_LEVEL);
  localparam logic [9:0]    X_LAST  = 10'(OUT_WIDTH - 1);
  localparam logic [9:0]    Y_LAST  = 10'(MAX_LINES - 1);

  cap_state_e    r_state;
  cap_state_e    w_state_d;
  logic [9:0]    r_x;
  logic [9:0]    w_x_d;
  logic [9:0]    r_y;
  logic [9:0]    w_y_d;
  logic [9:0]    w_y_inc;
  logic [13:0]   r_acc;
  logic [13:0]   w_acc_d;
  logic [13:0]   w_sum;
  logic [13:0]   w_d;
  logic [23:0]   w_prod;
  logic [15:0]   w_scaled;
  logic [7:0]    w_luma;
  logic [PW-1:0] r_ph;
  logic [PW-1:0] w_ph_d;
  logic          w_vs;
  logic          w_take;
  logic          w_emit;
  pixel_t        r_pix;
  logic          r_pix_vld;
  logic          r_ovf;
  pixel_t        w_head;
  pixel_t        w_out;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  assign w_vs    = bus.sample_valid & bus.v_sync_pulse;
  assign w_y_inc = (r_y >= Y_LAST) ? Y_LAST : r_y + 1'b1;

  assign w_sum    = r_acc + {2'b00, bus.adc_data};
  assign w_d      = (w_sum > BLK) ? w_sum - BLK : '0;
  assign w_prod   = 24'(w_d) * 24'(GAIN_Q8);
  assign w_scaled = 16'(w_prod >> 8);
  assign w_luma   = (|w_scaled[15:8]) ? 8'hFF : w_scaled[7:0];

  always_comb begin
    w_state_d = r_state;
    w_x_d     = r_x;
    w_y_d     = r_y;
    w_acc_d   = r_acc;
    w_ph_d    = r_ph;
    w_take    = 1'b0;
    w_emit    = 1'b0;
    if (w_vs) begin
      w_state_d = WAIT_LINE;
      w_x_d     = '0;
      w_y_d     = '0;
      w_acc_d   = '0;
      w_ph_d    = '0;
    end else if (bus.sample_valid) begin
      unique case (r_state)
        IDLE: ;
        WAIT_LINE: begin
          if (bus.h_sync_pulse) begin
            w_x_d   = '0;
            w_y_d   = w_y_inc;
            w_acc_d = '0;
            w_ph_d  = '0;
          end else if (bus.active_video) begin
            w_take = 1'b1;
          end
        end
        CAPTURE: begin
          if (bus.active_video) begin
            w_take = 1'b1;
          end else begin
            w_state_d = DONE_LINE;
            w_acc_d   = '0;
            w_ph_d    = '0;
          end
        end
        // The sync that leaves DONE_LINE starts the next line.
        DONE_LINE: begin
          if (bus.h_sync_pulse) begin
            w_state_d = WAIT_LINE;
            w_x_d     = '0;
            w_y_d     = w_y_inc;
            w_acc_d   = '0;
            w_ph_d    = '0;
          end
        end
        default: w_state_d = IDLE;
      endcase
      if (w_take) begin
        w_state_d = CAPTURE;
        if (r_ph == PH_LAST) begin
          w_emit  = 1'b1;
          w_acc_d = '0;
          w_ph_d  = '0;
          w_x_d   = r_x + 1'b1;
          if (r_x == X_LAST) w_state_d = DONE_LINE;
        end else begin
          w_acc_d = w_sum;
          w_ph_d  = r_ph + 1'b1;
        end
      end
    end
  end

  assign w_pop  = ~w_empty & bus.pix_ready;
  assign w_push = r_pix_vld & (~w_full | w_pop);
  assign w_drop = r_pix_vld & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_acc     <= '0;
      r_ph      <= '0;
      r_pix     <= '0;
      r_pix_vld <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_x       <= w_x_d;
      r_y       <= w_y_d;
      r_acc     <= w_acc_d;
      r_ph      <= w_ph_d;
      r_pix_vld <= w_emit;
      if (w_emit) begin
        r_pix <= '{data: w_luma, x: r_x, y: r_y,
                   sof: (r_x == '0) && (r_y == '0),
                   eol: (r_x == X_LAST)};
      end
      if (w_drop) r_ovf <= 1'b1;
      else if (w_vs) r_ovf <= 1'b0;
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (pixel_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (r_pix),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_out         = w_empty ? '0 : w_head;
  assign bus.pix_valid = ~w_empty;
  assign bus.pix_data  = w_out.data;
  assign bus.pix_x     = w_out.x;
  assign bus.pix_y     = w_out.y;
  assign bus.pix_sof   = w_out.sof;
  assign bus.pix_eol   = w_out.eol;
  assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_video_line_capture.sv
// Randomised line/field stimulus scored against a sample-level
// behavioural model of decimation, gain and raster tagging.
module tb_video_line_capture;

  localparam int DECIM     = 3;
  localparam int OUT_WIDTH = 640;
  localparam int MAX_LINES = 263;
  localparam int BLACK     = 1024;
  localparam int GAIN      = 11;
  localparam int DEPTH     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_line_capture_if bus();

  video_line_capture #(
    .DECIM       (DECIM),
    .OUT_WIDTH   (OUT_WIDTH),
    .MAX_LINES   (MAX_LINES),
    .BLACK_LEVEL (BLACK),
    .GAIN_Q8     (GAIN),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [29:0] exp_q[$];
  logic [29:0] mon_got;
  int pops, eols, sofs, last_y;
  int rdy_mode;
  bit gaps, hold_chk;

  bit m_field, m_started, m_done, m_hold;
  int m_y, m_gx, m_gn, m_gsum, m_held;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] exp_pix(int x, int y, int sum);
    int d, p;
    d = sum - DECIM * BLACK;
    if (d < 0) d = 0;
    p = (d * GAIN) / 256;
    if (p > 255) p = 255;
    return {8'(p), 10'(x), 10'(y), x == 0 && y == 0, x == OUT_WIDTH - 1};
  endfunction

  task automatic m_sync(input bit vs);
    if (vs) begin
      m_field = 1;
      m_y = 0;
    end else if (m_field && m_y < MAX_LINES - 1) begin
      m_y++;
    end
    m_started = 0;
    m_done = 0;
    m_gx = 0;
    m_gn = 0;
    m_gsum = 0;
  endtask

  task automatic m_active(input int v);
    if (m_field && !m_done) begin
      m_started = 1;
      m_gsum += v;
      m_gn++;
      if (m_gn == DECIM) begin
        if (!m_hold || m_held < DEPTH) begin
          exp_q.push_back(exp_pix(m_gx, m_y, m_gsum));
          m_held++;
        end
        m_gx++;
        m_gn = 0;
        m_gsum = 0;
        if (m_gx == OUT_WIDTH) m_done = 1;
      end
    end
  endtask

  task automatic m_blank();
    if (m_started) begin
      m_done = 1;
      m_gn = 0;
      m_gsum = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: bus.pix_ready = 1'b1;
      1: bus.pix_ready = ($urandom_range(0, 3) != 0);
      default: bus.pix_ready = 1'b0;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input bit hs, input bit vs, input bit av, input int v);
    if (gaps && $urandom_range(0, 7) == 0) begin
      repeat ($urandom_range(1, 2)) begin
        bus.sample_valid = 1'b0;
        bus.adc_data = 12'($urandom);
        bus.h_sync_pulse = 1'($urandom);
        bus.v_sync_pulse = 1'($urandom);
        bus.active_video = 1'($urandom);
        tick();
      end
    end
    bus.sample_valid = 1'b1;
    bus.adc_data = 12'(v);
    bus.h_sync_pulse = hs;
    bus.v_sync_pulse = vs;
    bus.active_video = av;
    tick();
    bus.sample_valid = 1'b0;
    bus.h_sync_pulse = 1'b0;
    bus.v_sync_pulse = 1'b0;
  endtask

  task automatic do_sync(input bit vs, input bit av = 1'b0);
    drive(1'b1, vs, av, $urandom_range(0, 4095));
    m_sync(vs);
  endtask

  task automatic blank(input int n);
    repeat (n) begin
      drive(1'b0, 1'b0, 1'b0, $urandom_range(0, 4095));
      m_blank();
    end
  endtask

  task automatic active(input int n, input int v);
    int s;
    repeat (n) begin
      s = (v < 0) ? int'($urandom_range(0, 4095)) : v;
      drive(1'b0, 1'b0, 1'b1, s);
      m_active(s);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      tick();
      t++;
    end
    chk("drain_q", exp_q.size(), 0);
    idle(4);
    chk("drain_empty", bus.pix_valid, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_got = {bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_sof, bus.pix_eol};
      if (hold_chk) begin
        chk("hold_valid", bus.pix_valid, 1);
        if (exp_q.size() > 0) chk("hold_fields", mon_got, exp_q[0]);
        else chk("hold_q", exp_q.size(), 1);
      end
      if (bus.pix_valid && bus.pix_ready) begin
        pops++;
        eols += int'(bus.pix_eol);
        sofs += int'(bus.pix_sof);
        last_y = int'(bus.pix_y);
        if (exp_q.size() == 0) chk("unexp_pix", exp_q.size(), 1);
        else chk("pix", mon_got, exp_q.pop_front());
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.sample_valid = 1'b0;
    bus.adc_data = '0;
    bus.h_sync_pulse = 1'b0;
    bus.v_sync_pulse = 1'b0;
    bus.active_video = 1'b0;
    bus.pix_ready = 1'b1;
    rdy_mode = 0;
    gaps = 0;
    hold_chk = 0;
    m_field = 0; m_started = 0; m_done = 0; m_hold = 0;
    m_y = 0; m_gx = 0; m_gn = 0; m_gsum = 0; m_held = 0;
    pops = 0; eols = 0; sofs = 0; last_y = 0;
    idle(3);
    chk("rst_valid", bus.pix_valid, 0);
    chk("rst_fields", {bus.pix_data, bus.pix_x, bus.pix_y,
                       bus.pix_sof, bus.pix_eol}, 0);
    chk("rst_ovf", bus.overflow, 0);
    rst_n = 1'b1;
    idle(2);

    // flat mid-grey full line
    do_sync(1); blank(4); active(1920, 2048); blank(4); drain();
    chk("flat_count", pops, 640);
    chk("flat_eol", eols, 1);
    chk("flat_sof", sofs, 1);

    // clamp below black and at full scale
    pops = 0;
    do_sync(0); blank(2); active(30, 900); blank(2);
    do_sync(0); blank(2); active(30, 4095); blank(2); drain();
    chk("clamp_count", pops, 20);

    // active window ends early with a partial group
    pops = 0; eols = 0;
    do_sync(0); blank(3); active(1000, -1); blank(3); drain();
    chk("short_count", pops, 333);
    chk("short_eol", eols, 0);

    // sink stalled for a whole line
    rdy_mode = 2; tick();
    m_hold = 1; m_held = 0;
    do_sync(1); blank(2); active(9, -1);
    hold_chk = 1;
    active(1911, -1); blank(4); idle(3);
    chk("ovf_set", bus.overflow, 1);
    hold_chk = 0; m_hold = 0; rdy_mode = 0;
    drain();
    chk("ovf_sticky", bus.overflow, 1);

    // overflow clear, then field restart mid-line
    pops = 0; sofs = 0;
    do_sync(1);
    chk("ovf_clear", bus.overflow, 0);
    blank(2); active(601, -1);
    do_sync(1, 1'b1); blank(2); active(30, -1); blank(2); drain();
    chk("abort_count", pops, 210);
    chk("abort_sof", sofs, 2);

    // random lines, gaps and back-pressure
    rdy_mode = 1; gaps = 1;
    do_sync(1);
    for (int i = 0; i < 8; i++) begin
      blank($urandom_range(0, 5));
      active((i == 3) ? 1950 : int'($urandom_range(0, 300)), -1);
      blank($urandom_range(1, 4));
      do_sync(i == 5);
    end
    drain();
    chk("rand_ovf", bus.overflow, 0);

    // line counter saturation
    rdy_mode = 0; gaps = 0;
    do_sync(1);
    repeat (265) begin
      blank(1); active(3, -1); blank(1); do_sync(0);
    end
    drain();
    chk("y_sat", last_y, MAX_LINES - 1);

    // reset mid-capture with pixels buffered
    rdy_mode = 2; tick();
    do_sync(1); blank(2); active(9, -1); idle(3);
    chk("pre_rst_valid", bus.pix_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", bus.pix_valid, 0);
    chk("rst_async_fields", {bus.pix_data, bus.pix_x, bus.pix_y,
                             bus.pix_sof, bus.pix_eol}, 0);
    chk("rst_async_ovf", bus.overflow, 0);
    exp_q.delete();
    m_field = 0; m_started = 0; m_done = 0;
    m_gx = 0; m_gn = 0; m_gsum = 0;
    idle(2);
    rst_n = 1'b1;
    rdy_mode = 0; pops = 0;
    do_sync(0); blank(2); active(30, -1); blank(2); idle(5);
    chk("post_rst_pops", pops, 0);
    chk("post_rst_valid", bus.pix_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
